fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_RESET, default 32'h0000_3000, address of first fetched instruction.
REQ-002 Parameter: IM_BASE, default 32'h0000_3000, base subtracted to form the word index.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high.
REQ-005 Port: stall  input  1  hazard-unit hold request for F and D stages.
REQ-006 Port: pc_sel  input  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 register.
REQ-007 Port: npc_beq  input  32  branch next-PC computed in D.
REQ-008 Port: jr_target  input  32  forwarded rs value for jr/jalr.
REQ-009 Port: instr_F  input  32  instruction word returned combinationally by IM for pc_F.
REQ-010 Port: pc_F  output  32  current fetch address.
REQ-011 Port: im_index  output  10  word index into IM: (pc_F - IM_BASE)[11:2].
REQ-012 Port: instr_D  output  32  IF/ID instruction.
REQ-013 Port: PC4_D  output  32  IF/ID pc+4.
REQ-014 Port: PC8_D  output  32  IF/ID pc+8, link value for jal/jalr.
REQ-015 Port: valid_D  output  1  IF/ID holds a real fetched instruction.
REQ-016 Port: misalign_F  output  1  pc_F[1:0] != 0 (error flag, registered with PC).

Function
REQ-017 The block SHALL hold a PC register and an IF/ID register, both updated only on rising clk.
REQ-018 Next PC when stall=0: seq = pc_F+4; branch = npc_beq; jump = {PC4_D[31:28], instr_D[25:0], 2'b00}; register = {jr_target[31:2], 2'b00}.
REQ-019 pc_sel values 01/10/11 SHALL be honoured only when valid_D=1; otherwise seq is used.
REQ-020 misalign_F SHALL be set on the cycle PC loads a register target whose jr_target[1:0] != 0, cleared on any other PC load.
REQ-021 All PC arithmetic SHALL be modulo 2^32; pc_F=32'hFFFF_FFFC with seq yields 32'h0000_0000.
REQ-022 When stall=0, IF/ID SHALL capture instr_F, pc_F+4, pc_F+8, and set valid_D=1 in the same edge the PC advances (one-cycle F->D latency).
REQ-023 When stall=1, PC, misalign_F and entire IF/ID SHALL hold; pc_sel is ignored that cycle.
REQ-024 Branch delay slot: a redirect SHALL NOT flush IF/ID; the instruction fetched alongside the branch in D is kept.
REQ-025 im_index SHALL be combinational from pc_F.

Reset
REQ-026 On reset=1 at a rising edge: pc_F=PC_RESET, misalign_F=0, instr_D=0, PC4_D=0, PC8_D=0, valid_D=0.
REQ-027 reset SHALL dominate stall and pc_sel, including mid-stall and on a redirect cycle.
REQ-028 First cycle after reset release SHALL fetch PC_RESET; valid_D becomes 1 one edge later (if not stalled).

Structure
REQ-029 Shared package SHALL hold PC_RESET, IM_BASE defaults and the pc_sel encodings (PCSEL_SEQ, PCSEL_BR, PCSEL_J, PCSEL_JR).
REQ-030 One sub-module, if_id_reg (IF/ID pipeline register with enable and synchronous reset), SHALL be instantiated; PC logic stays in fetch_unit.

Verification
REQ-031 Reset, 3 idle cycles stall=0 pc_sel=00 -> pc_F 3000,3004,3008,300C; PC4_D trails by one cycle (3004,3008,...); valid_D 0 then 1.
REQ-032 D holds branch at PC4_D=3008, pc_sel=01, npc_beq=3020 -> next pc_F=3020; IF/ID holds delay-slot instr from 3008, valid_D=1.
REQ-033 instr_D=0x0C000C10 (jal), PC4_D=3010, pc_sel=10 -> pc_F=3040 next edge, PC8_D=3014 presented while jal in D.
REQ-034 stall=1 for 2 cycles with pc_sel=01 -> pc_F, instr_D, PC4_D unchanged; redirect occurs only after stall drops.
REQ-035 pc_sel=11, jr_target=0x0000_3102 -> pc_F=3100, misalign_F=1; next seq load clears it.
REQ-036 reset asserted during stall=1 with pc_F=3050 -> next edge pc_F=3000, valid_D=0; pc_F=FFFF_FFFC seq -> 0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default reset/IM base addresses
// and the next-PC source encodings driven by the control unit on pc_sel.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_BR  = 2'b01,
        PCSEL_J   = 2'b10,
        PCSEL_JR  = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk      : rising-edge clock
//   reset    : synchronous active-high clear (dominates en)
//   en       : capture enable (low = hold everything)
//   instr_in : fetched instruction        -> instr_o
//   pc4_in   : fetch pc + 4               -> pc4_o
//   pc8_in   : fetch pc + 8 (link value)  -> pc8_o
//   valid_o  : register holds a real fetched instruction
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] pc8_in,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic [31:0] pc8_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc8_q, pc8_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (en) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            pc8_d   = pc8_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc4_q   <= '0;
            pc8_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign pc8_o   = pc8_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   stall       : hold PC, misalign flag and IF/ID
//   pc_sel      : next-PC source (seq / branch / jump / register)
//   npc_beq     : branch target from D
//   jr_target   : forwarded rs for jr/jalr
//   instr_F     : IM read data for pc_F
//   pc_F        : current fetch address
//   im_index    : IM word index (pc_F - IM_BASE)[11:2]
//   instr_D, PC4_D, PC8_D, valid_D : IF/ID contents
//   misalign_F  : last PC load came from a non-word-aligned register target
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] npc_beq,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic [9:0]  im_index,
    output logic [31:0] instr_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        valid_D,
    output logic        misalign_F
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_plus4, pc_plus8;
    pc_sel_e     sel_eff;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        pc_plus8   = pc_q + 32'd8;
        // Redirects are only meaningful when D holds a real instruction.
        sel_eff    = valid_D ? pc_sel_e'(pc_sel) : PCSEL_SEQ;
        pc_d       = pc_plus4;
        misalign_d = 1'b0;
        if (stall) begin
            pc_d       = pc_q;
            misalign_d = misalign_q;
        end else begin
            case (sel_eff)
                PCSEL_BR: pc_d = npc_beq;
                PCSEL_J:  pc_d = {PC4_D[31:28], instr_D[25:0], 2'b00};
                PCSEL_JR: begin
                    pc_d       = {jr_target[31:2], 2'b00};
                    misalign_d = |jr_target[1:0];
                end
                default:  pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_F       = pc_q;
    assign misalign_F = misalign_q;

    // Bits [11:2] of (pc - IM_BASE), with the borrow out of bits [1:0]
    // applied explicitly so no unused low difference bits are created.
    assign im_index = pc_q[11:2] - IM_BASE[11:2]
                    - {9'b0, (pc_q[1:0] < IM_BASE[1:0])};

    // No flush on redirect: the delay-slot instruction is always kept.
    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .en       (~stall),
        .instr_in (instr_F),
        .pc4_in   (pc_plus4),
        .pc8_in   (pc_plus8),
        .instr_o  (instr_D),
        .pc4_o    (PC4_D),
        .pc8_o    (PC8_D),
        .valid_o  (valid_D)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] P_RESET = 32'h0000_3000;
    localparam logic [31:0] P_BASE  = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] npc_beq;
    logic [31:0] jr_target;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic [9:0]  im_index;
    logic [31:0] instr_D;
    logic [31:0] PC4_D;
    logic [31:0] PC8_D;
    logic        valid_D;
    logic        misalign_F;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_RESET (P_RESET),
        .IM_BASE  (P_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .npc_beq    (npc_beq),
        .jr_target  (jr_target),
        .instr_F    (instr_F),
        .pc_F       (pc_F),
        .im_index   (im_index),
        .instr_D    (instr_D),
        .PC4_D      (PC4_D),
        .PC8_D      (PC8_D),
        .valid_D    (valid_D),
        .misalign_F (misalign_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: a jal at 0x300C, a pc-derived pattern elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_300C) return 32'h0C00_0C10;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign instr_F = imem(pc_F);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_mis,
                             input logic [31:0] e_instr, input logic [31:0] e_p4,
                             input logic [31:0] e_p8, input logic e_v);
        logic [31:0] e_idx;
        e_idx = (e_pc - P_BASE) >> 2;
        check({tag, ".pc_F"},       pc_F,               e_pc);
        check({tag, ".misalign_F"}, {31'b0, misalign_F}, {31'b0, e_mis});
        check({tag, ".instr_D"},    instr_D,            e_instr);
        check({tag, ".PC4_D"},      PC4_D,              e_p4);
        check({tag, ".PC8_D"},      PC8_D,              e_p8);
        check({tag, ".valid_D"},    {31'b0, valid_D},   {31'b0, e_v});
        check({tag, ".im_index"},   {22'b0, im_index},  {22'b0, e_idx[9:0]});
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic [1:0]  sel;
        logic [31:0] npc;
        logic [31:0] jr;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_v;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic [1:0] sel,
                                input logic [31:0] npc, input logic [31:0] jr,
                                input logic [31:0] e_pc, input logic [31:0] e_p4,
                                input logic e_v, input logic e_mis);
        vec_t v;
        v.rst = rst; v.st = st; v.sel = sel; v.npc = npc; v.jr = jr;
        v.e_pc = e_pc; v.e_p4 = e_p4; v.e_v = e_v; v.e_mis = e_mis;
        return v;
    endfunction

    vec_t tbl[24];

    // Reference model state (architectural view of the fetch stage).
    logic [31:0] m_pc, m_i, m_p4, m_p8, m_nxt;
    logic        m_v, m_mis;
    logic [1:0]  m_sel;

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 2'b00; npc_beq = '0; jr_target = '0;

        // Sequential fetch after reset
        tbl[0]  = mk(1, 0, 2'b00, 0, 0, 32'h3000, 32'h0000, 0, 0);
        tbl[1]  = mk(0, 0, 2'b00, 0, 0, 32'h3004, 32'h3004, 1, 0);
        tbl[2]  = mk(0, 0, 2'b00, 0, 0, 32'h3008, 32'h3008, 1, 0);
        // Branch in D, delay slot (3008) captured
        tbl[3]  = mk(0, 0, 2'b01, 32'h3020, 0, 32'h3020, 32'h300C, 1, 0);
        tbl[4]  = mk(0, 0, 2'b00, 0, 0, 32'h3024, 32'h3024, 1, 0);
        // Walk up to the jal at 300C
        tbl[5]  = mk(1, 0, 2'b01, 32'h5555_0000, 0, 32'h3000, 32'h0000, 0, 0);
        tbl[6]  = mk(0, 0, 2'b00, 0, 0, 32'h3004, 32'h3004, 1, 0);
        tbl[7]  = mk(0, 0, 2'b00, 0, 0, 32'h3008, 32'h3008, 1, 0);
        tbl[8]  = mk(0, 0, 2'b00, 0, 0, 32'h300C, 32'h300C, 1, 0);
        tbl[9]  = mk(0, 0, 2'b00, 0, 0, 32'h3010, 32'h3010, 1, 0);
        tbl[10] = mk(0, 0, 2'b10, 0, 0, 32'h3040, 32'h3014, 1, 0);
        // Stall for two cycles with a pending branch
        tbl[11] = mk(0, 1, 2'b01, 32'h3080, 0, 32'h3040, 32'h3014, 1, 0);
        tbl[12] = mk(0, 1, 2'b01, 32'h3080, 0, 32'h3040, 32'h3014, 1, 0);
        tbl[13] = mk(0, 0, 2'b01, 32'h3080, 0, 32'h3080, 32'h3044, 1, 0);
        // Register target with misaligned low bits, held through a stall
        tbl[14] = mk(0, 0, 2'b11, 0, 32'h3102, 32'h3100, 32'h3084, 1, 1);
        tbl[15] = mk(0, 1, 2'b00, 0, 0, 32'h3100, 32'h3084, 1, 1);
        tbl[16] = mk(0, 0, 2'b00, 0, 0, 32'h3104, 32'h3104, 1, 0);
        // Reset during stall, reset on a redirect cycle
        tbl[17] = mk(0, 0, 2'b01, 32'h3050, 0, 32'h3050, 32'h3108, 1, 0);
        tbl[18] = mk(1, 1, 2'b01, 32'h3200, 0, 32'h3000, 32'h0000, 0, 0);
        tbl[19] = mk(1, 0, 2'b10, 0, 0, 32'h3000, 32'h0000, 0, 0);
        // Redirect ignored while D is empty
        tbl[20] = mk(0, 0, 2'b01, 32'hFFFF_FFFC, 0, 32'h3004, 32'h3004, 1, 0);
        // Wrap-around of sequential fetch
        tbl[21] = mk(0, 0, 2'b01, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h3008, 1, 0);
        tbl[22] = mk(0, 0, 2'b00, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 0);
        tbl[23] = mk(0, 0, 2'b00, 0, 0, 32'h0000_0004, 32'h0000_0004, 1, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            stall     = tbl[i].st;
            pc_sel    = tbl[i].sel;
            npc_beq   = tbl[i].npc;
            jr_target = tbl[i].jr;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_mis,
                      tbl[i].e_v ? imem(tbl[i].e_p4 - 32'd4) : 32'h0,
                      tbl[i].e_p4,
                      tbl[i].e_v ? tbl[i].e_p4 + 32'd4 : 32'h0,
                      tbl[i].e_v);
        end

        // Randomized phase against the reference model, starting from reset
        m_pc = '0; m_i = '0; m_p4 = '0; m_p8 = '0; m_v = 1'b0; m_mis = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reset     = (n == 0) || ($urandom_range(0, 39) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            pc_sel    = 2'($urandom_range(0, 3));
            npc_beq   = $urandom;
            jr_target = $urandom;
            if (reset) begin
                m_pc = P_RESET; m_mis = 1'b0;
                m_i = '0; m_p4 = '0; m_p8 = '0; m_v = 1'b0;
            end else if (!stall) begin
                m_sel = m_v ? pc_sel : 2'b00;
                case (m_sel)
                    2'b01:   m_nxt = npc_beq;
                    2'b10:   m_nxt = (m_p4 & 32'hF000_0000) | ((m_i & 32'h03FF_FFFF) << 2);
                    2'b11:   m_nxt = jr_target & ~32'd3;
                    default: m_nxt = m_pc + 32'd4;
                endcase
                m_mis = (m_sel == 2'b11) && (jr_target % 4 != 0);
                m_i   = imem(m_pc);
                m_p4  = m_pc + 32'd4;
                m_p8  = m_pc + 32'd8;
                m_v   = 1'b1;
                m_pc  = m_nxt;
            end
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", n), m_pc, m_mis, m_i, m_p4, m_p8, m_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
